alu_mc: RTL and testbench

- Parametrised, registered successor to the datapath ALU.
- Adds a valid/ready handshake and sequential multi-cycle unsigned multiply and divide that produce MIPS-style HI/LO results.
- Single-cycle ops (AND/OR/ADD/SUB/SLT/NOR) return after one clock.
- Sits in EX stage; stalls the pipeline via in_ready while a MULTU or DIVU runs.

---
 rtl/alu_mc.sv | 188 ++++++++++++++++++
 tb/tb_alu_mc.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
// Registered multi-cycle ALU: single-cycle logic/arith ops plus shift-add MULTU and restoring DIVU (HI/LO).
// Optional signed-overflow output enabled by defining ALU_MC_OVF_EN.
module alu_mc #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ctl,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic             out_valid,
  output logic [WIDTH-1:0] dataOut,
  output logic [WIDTH-1:0] hiOut,
  output logic             zero,
  output logic             busy
`ifdef ALU_MC_OVF_EN
  ,
  output logic             ovf
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV
  } state_e;

  typedef enum logic [3:0] {
    OP_AND   = 4'b0000,
    OP_OR    = 4'b0001,
    OP_ADD   = 4'b0010,
    OP_SUB   = 4'b0110,
    OP_SLT   = 4'b0111,
    OP_NOR   = 4'b1100,
    OP_MULTU = 4'b1000,
    OP_DIVU  = 4'b1001
  } op_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [WIDTH-1:0] hout_q, hout_d;
  logic             zero_q, zero_d;
  logic             vld_q, vld_d;

  logic [WIDTH-1:0] sum_add, sum_sub, alu_res;
  logic             ovf_sub, slt;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_sh, div_diff;

  assign sum_add = dataA + dataB;
  assign sum_sub = dataA - dataB;
  // SLT takes the sign of A-B corrected by overflow so it stays right when the subtraction wraps.
  assign ovf_sub = (dataA[WIDTH-1] != dataB[WIDTH-1]) && (sum_sub[WIDTH-1] != dataA[WIDTH-1]);
  assign slt     = sum_sub[WIDTH-1] ^ ovf_sub;

  always_comb begin
    alu_res = dataA & dataB;
    case (ctl)
      OP_OR:   alu_res = dataA | dataB;
      OP_ADD:  alu_res = sum_add;
      OP_SUB:  alu_res = sum_sub;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, slt};
      OP_NOR:  alu_res = ~(dataA | dataB);
      default: alu_res = dataA & dataB;
    endcase
  end

  // hi/lo form one 2W shift register: multiplier/dividend starts in lo, partial result in hi.
  assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
  assign div_sh   = {hi_q, lo_q[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, opnd_q};

`ifdef ALU_MC_OVF_EN
  logic ovf_q, ovf_d, ovf_add, alu_ovf;
  assign ovf_add = (dataA[WIDTH-1] == dataB[WIDTH-1]) && (sum_add[WIDTH-1] != dataA[WIDTH-1]);
  assign alu_ovf = (ctl == OP_ADD) ? ovf_add : (ctl == OP_SUB) ? ovf_sub : 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    opnd_d  = opnd_q;
    dout_d  = dout_q;
    hout_d  = hout_q;
    zero_d  = zero_q;
    vld_d   = 1'b0;
`ifdef ALU_MC_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (ctl == OP_MULTU || ctl == OP_DIVU) begin
            state_d = (ctl == OP_MULTU) ? S_MUL : S_DIV;
            cnt_d   = '0;
            hi_d    = '0;
            lo_d    = (ctl == OP_MULTU) ? dataB : dataA;
            opnd_d  = (ctl == OP_MULTU) ? dataA : dataB;
          end else begin
            dout_d = alu_res;
            hout_d = '0;
            zero_d = (alu_res == '0);
            vld_d  = 1'b1;
`ifdef ALU_MC_OVF_EN
            ovf_d  = alu_ovf;
`endif
          end
        end
      end
      S_MUL: begin
        hi_d  = mul_sum[WIDTH:1];
        lo_d  = {mul_sum[0], lo_q[WIDTH-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
      end
      S_DIV: begin
        if (!div_diff[WIDTH]) begin
          hi_d = div_diff[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
          hi_d = div_sh[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + CNT_W'(1);
      end
      default: state_d = S_IDLE;
    endcase

    if (state_q != S_IDLE && cnt_d == CNT_W'(WIDTH)) begin
      state_d = S_IDLE;
      dout_d  = lo_d;
      hout_d  = hi_d;
      zero_d  = (lo_d == '0);
      vld_d   = 1'b1;
`ifdef ALU_MC_OVF_EN
      ovf_d   = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      opnd_q  <= '0;
      dout_q  <= '0;
      hout_q  <= '0;
      zero_q  <= 1'b1;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      opnd_q  <= opnd_d;
      dout_q  <= dout_d;
      hout_q  <= hout_d;
      zero_q  <= zero_d;
      vld_q   <= vld_d;
    end
  end

`ifdef ALU_MC_OVF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end
  assign ovf = ovf_q;
`endif

  assign busy      = (state_q != S_IDLE);
  assign in_ready  = ~busy;
  assign out_valid = vld_q;
  assign dataOut   = dout_q;
  assign hiOut     = hout_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: arithmetic reference model with per-cycle compare plus directed literal checks.
module tb_alu_mc;
  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic [3:0]   ctl = '0;
  logic [W-1:0] dataA = '0, dataB = '0;
  logic         in_ready, out_valid, zero, busy;
  logic [W-1:0] dataOut, hiOut;

  logic         v8 = 1'b0;
  logic [3:0]   ctl8 = '0;
  logic [7:0]   a8 = '0, b8 = '0;
  logic         in_ready8, out_valid8, zero8, busy8;
  logic [7:0]   do8, ho8;
`ifdef ALU_MC_OVF_EN
  logic         ovf, ovf8;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .ctl(ctl),
    .dataA(dataA), .dataB(dataB), .out_valid(out_valid), .dataOut(dataOut), .hiOut(hiOut),
    .zero(zero), .busy(busy)
`ifdef ALU_MC_OVF_EN
    , .ovf(ovf)
`endif
  );

  alu_mc #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(in_ready8), .ctl(ctl8),
    .dataA(a8), .dataB(b8), .out_valid(out_valid8), .dataOut(do8), .hiOut(ho8),
    .zero(zero8), .busy(busy8)
`ifdef ALU_MC_OVF_EN
    , .ovf(ovf8)
`endif
  );

  typedef struct {
    int          due;
    logic [63:0] lo;
    logic [63:0] hi;
    logic        ov;
  } exp_t;

  exp_t        q[$];
  int          edge_n   = 0;
  int          busy_end = 0;
  logic [63:0] h_lo = '0, h_hi = '0;
  logic        h_ov = 1'b0;
  logic        exp_v, exp_busy;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit is_multi(input logic [3:0] c);
    return (c == 4'b1000) || (c == 4'b1001);
  endfunction

  // Reference results from plain integer arithmetic on w-bit operands.
  function automatic exp_t model(input int w, input logic [3:0] c, input logic [63:0] a,
                                 input logic [63:0] b, input int e);
    exp_t        r;
    logic [63:0] m;
    longint      lim, sa, sb, s;
    m    = (64'd1 << w) - 64'd1;
    lim  = longint'(64'd1 << (w - 1));
    sa   = a[w-1] ? longint'(a) - 2 * lim : longint'(a);
    sb   = b[w-1] ? longint'(b) - 2 * lim : longint'(b);
    r.lo = '0; r.hi = '0; r.ov = 1'b0;
    r.due = is_multi(c) ? e + w : e;
    case (c)
      4'b0001: r.lo = a | b;
      4'b0010: begin s = sa + sb; r.lo = 64'(s) & m; r.ov = (s >= lim) || (s < -lim); end
      4'b0110: begin s = sa - sb; r.lo = 64'(s) & m; r.ov = (s >= lim) || (s < -lim); end
      4'b0111: r.lo = (sa < sb) ? 64'd1 : 64'd0;
      4'b1100: r.lo = ~(a | b) & m;
      4'b1000: begin r.lo = (a * b) & m; r.hi = (a * b) >> w; end
      4'b1001: begin
        if (b == 0) begin r.lo = m; r.hi = a; end
        else begin r.lo = a / b; r.hi = a % b; end
      end
      default: r.lo = a & b;
    endcase
    return r;
  endfunction

  // Model: accepts at rising edges when not busy, queues the result with its due edge.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      q.delete();
      busy_end = 0;
    end else begin
      edge_n++;
      if (in_valid && edge_n > busy_end) begin
        q.push_back(model(W, ctl, 64'(dataA), 64'(dataB), edge_n));
        if (is_multi(ctl)) busy_end = edge_n + W;
      end
    end
  end

  // Compare every cycle on the falling edge.
  initial forever begin
    @(negedge clk);
    exp_v = 1'b0;
    if (!rst_n) begin
      h_lo = '0; h_hi = '0; h_ov = 1'b0;
    end else if (q.size() != 0 && q[0].due == edge_n) begin
      exp_v = 1'b1;
      h_lo = q[0].lo; h_hi = q[0].hi; h_ov = q[0].ov;
      void'(q.pop_front());
    end
    exp_busy = rst_n && (edge_n < busy_end);
    chk("out_valid", 64'(out_valid), 64'(exp_v));
    chk("dataOut", 64'(dataOut), h_lo);
    chk("hiOut", 64'(hiOut), h_hi);
    chk("zero", 64'(zero), 64'(h_lo == 0));
    chk("busy", 64'(busy), 64'(exp_busy));
    chk("in_ready", 64'(in_ready), 64'(!exp_busy));
`ifdef ALU_MC_OVF_EN
    chk("ovf", 64'(ovf), 64'(h_ov));
`endif
  end

  task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       output int k);
    int n;
    bit acc;
    n = 0; acc = 1'b0;
    ctl = c; dataA = a; dataB = b; in_valid = 1'b1;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    k = edge_n;
    if (!acc) begin
      n_checks++; n_fail++;
      $display("FAIL issue_accept: got no accept, expected accept within 200 cycles");
    end
  endtask

  task automatic wait_result(input int k, output int lat);
    int n;
    bit seen;
    n = 0; seen = 1'b0;
    while (!seen && n < 100) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
      else n++;
    end
    lat = edge_n - k;
    if (!seen) begin
      n_checks++; n_fail++;
      $display("FAIL wait_out_valid: got none, expected out_valid within 100 cycles");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish before t=200000");
    $fatal(1);
  end

  initial begin
    int k, lat, e1, e2, e3, n;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_dataOut", 64'(dataOut), 64'h0);
    chk("rst_zero", 64'(zero), 64'h1);
    chk("rst_in_ready", 64'(in_ready), 64'h1);
    @(posedge clk);
    #1 rst_n = 1'b1;

    issue(4'b0010, 32'h7FFF_FFFF, 32'h1, k);
    wait_result(k, lat);
    chk("add_latency", 64'(lat), 64'd0);
    chk("add_dataOut", 64'(dataOut), 64'h8000_0000);
    chk("add_zero", 64'(zero), 64'h0);
`ifdef ALU_MC_OVF_EN
    chk("add_ovf", 64'(ovf), 64'h1);
`endif

    issue(4'b0110, 32'd5, 32'd5, e1);
    chk("sub_dataOut", 64'(dataOut), 64'h0);
    chk("sub_zero", 64'(zero), 64'h1);
    issue(4'b0111, 32'h8000_0000, 32'h1, e2);
    chk("slt_min_dataOut", 64'(dataOut), 64'h1);
    chk("slt_min_out_valid", 64'(out_valid), 64'h1);
    issue(4'b0111, 32'h1, 32'hFFFF_FFFF, e3);
    chk("slt_neg_dataOut", 64'(dataOut), 64'h0);
    chk("b2b_accept_span", 64'(e3 - e1), 64'd2);

    issue(4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, k);
    ctl = 4'b0010; dataA = 32'd1; dataB = 32'd2; in_valid = 1'b1;
    @(negedge clk);
    chk("mul_busy", 64'(busy), 64'h1);
    chk("mul_in_ready", 64'(in_ready), 64'h0);
    wait_result(k, lat);
    chk("mul_latency", 64'(lat), 64'd32);
    chk("mul_lo", 64'(dataOut), 64'h1);
    chk("mul_hi", 64'(hiOut), 64'hFFFF_FFFE);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("held_add_dataOut", 64'(dataOut), 64'd3);
    chk("held_add_out_valid", 64'(out_valid), 64'h1);

    issue(4'b1001, 32'd100, 32'd7, k);
    wait_result(k, lat);
    chk("div_latency", 64'(lat), 64'd32);
    chk("div_quot", 64'(dataOut), 64'd14);
    chk("div_rem", 64'(hiOut), 64'd2);
    issue(4'b1001, 32'h1234, 32'h0, k);
    wait_result(k, lat);
    chk("div0_quot", 64'(dataOut), 64'hFFFF_FFFF);
    chk("div0_rem", 64'(hiOut), 64'h1234);
    chk("div0_zero", 64'(zero), 64'h0);

    issue(4'b1000, 32'd3, 32'd4, k);
    while (edge_n < k + 10) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    chk("abort_dataOut", 64'(dataOut), 64'h0);
    chk("abort_hiOut", 64'(hiOut), 64'h0);
    chk("abort_zero", 64'(zero), 64'h1);
    chk("abort_busy", 64'(busy), 64'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    issue(4'b0010, 32'd1, 32'd2, k);
    wait_result(k, lat);
    chk("post_rst_add", 64'(dataOut), 64'd3);

    @(posedge clk);
    #1;
    ctl8 = 4'b1000; a8 = 8'hFF; b8 = 8'h02; v8 = 1'b1;
    @(negedge clk);
    chk("w8_in_ready", 64'(in_ready8), 64'h1);
    @(posedge clk);
    #1;
    v8 = 1'b0;
    chk("w8_busy", 64'(busy8), 64'h1);
    n = 0;
    while (!out_valid8 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("w8_latency", 64'(n), 64'd8);
    chk("w8_hi", 64'(ho8), 64'h01);
    chk("w8_lo", 64'(do8), 64'hFE);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
